// File: rtl/ring_freq_meter.sv
// rtl/ring_freq_meter.sv - ring-oscillator frequency meter: Gray edge counter, CDC sync, gated sampling
module ring_freq_meter #(
    parameter int pRINGS  = 6,
    parameter int pSEL_W  = 3,
    parameter int pCNT_W  = 16,
    parameter int pGATE   = 1000,
    parameter int pSETTLE = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [pRINGS-1:0] i_ring,
    input  logic [pSEL_W-1:0] i_sel,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_valid,
    output logic [pCNT_W-1:0] o_count
);

    localparam int SLOTS = 2 ** pSEL_W;
    localparam int TMAX  = (pGATE > pSETTLE) ? pGATE : pSETTLE;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [pCNT_W-1:0] gray2bin(input logic [pCNT_W-1:0] g);
        logic [pCNT_W-1:0] b;
        b[pCNT_W-1] = g[pCNT_W-1];
        for (int i = pCNT_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [pCNT_W-1:0] bin2gray(input logic [pCNT_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [pSEL_W-1:0] sel_q;
    logic [SLOTS-1:0]  ring_ext;
    logic              ring_clk;
    logic [pCNT_W-1:0] gray_q;
    logic [pCNT_W-1:0] sync1_q;
    logic [pCNT_W-1:0] sync2_q;
    logic [pCNT_W-1:0] sync_bin;
    logic [pCNT_W-1:0] bin0_q;
    logic [pCNT_W-1:0] bin1_q;
    logic [TW-1:0]     timer_q;
    logic              timer_zero;
    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              take0;
    logic              take1;
    logic              finish;

    // Unpopulated select slots read as a constant 0, so such a run counts no edges.
    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        if (g < pRINGS) begin : g_used
            assign ring_ext[g] = i_ring[g];
        end else begin : g_empty
            assign ring_ext[g] = 1'b0;
        end
    end

    assign ring_clk = ring_ext[sel_q];

    always_ff @(posedge ring_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gray_q <= '0;
        end else begin
            gray_q <= bin2gray(gray2bin(gray_q) + 1'b1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gray_q;
            sync2_q <= sync1_q;
        end
    end

    assign sync_bin   = gray2bin(sync2_q);
    assign timer_zero = (timer_q == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = SETTLE;
            SETTLE:  if (timer_zero) state_d = GATE;
            GATE:    if (timer_zero) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        take0  = 1'b0;
        take1  = 1'b0;
        finish = 1'b0;
        case (state_q)
            IDLE:    accept = i_start;
            SETTLE:  take0  = timer_zero;
            GATE:    take1  = timer_zero;
            DONE:    finish = 1'b1;
            default: finish = 1'b0;
        endcase
    end

    // The timer is loaded with N-1 so that SETTLE and GATE each last exactly N cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer_q <= '0;
        end else if (accept) begin
            timer_q <= TW'(pSETTLE - 1);
        end else if (take0) begin
            timer_q <= TW'(pGATE - 1);
        end else if (!timer_zero) begin
            timer_q <= timer_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_q   <= '0;
            bin0_q  <= '0;
            bin1_q  <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_count <= '0;
        end else begin
            o_valid <= finish;
            if (accept) begin
                sel_q  <= i_sel;
                o_busy <= 1'b1;
            end
            if (take0) begin
                bin0_q <= sync_bin;
            end
            if (take1) begin
                bin1_q <= sync_bin;
            end
            if (finish) begin
                o_count <= bin1_q - bin0_q;
                o_busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_freq_meter.sv
// tb/tb_ring_freq_meter.sv - self-checking bench for ring_freq_meter with edge-count reference model
`timescale 1ns/1ps
module tb_ring_freq_meter;

    localparam int RINGS    = 6;
    localparam int SEL_W    = 3;
    localparam int CNT_W    = 16;
    localparam int GATE     = 1000;
    localparam int SETTLE   = 4;
    localparam int DONE_OFS = SETTLE + GATE + 1;
    localparam longint T_PS = longint'(GATE) * 10000;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [RINGS-1:0] ring;
    logic [SEL_W-1:0] sel   = '0;
    logic             start = 1'b0;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] count;

    int half_ps [RINGS] = '{1000, 1500, 2000, 3000, 5000, 20000};

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int     edge_n  = 0;
    bit     have    = 1'b0;
    int     acc     = 0;
    longint lo_cnt  = 0;
    longint hi_cnt  = 0;
    longint hold_lo = 0;
    longint hold_hi = 0;

    ring_freq_meter #(
        .pRINGS (RINGS),
        .pSEL_W (SEL_W),
        .pCNT_W (CNT_W),
        .pGATE  (GATE),
        .pSETTLE(SETTLE)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_ring (ring),
        .i_sel  (sel),
        .i_start(start),
        .o_busy (busy),
        .o_valid(valid),
        .o_count(count)
    );

    initial forever #5 clk = ~clk;

    for (genvar g = 0; g < RINGS; g++) begin : g_ring
        logic r = 1'b0;
        assign ring[g] = r;
        initial begin
            #(0.37 + 0.13 * g);
            forever begin
                #(real'(half_ps[g]) / 1000.0);
                r = ~r;
            end
        end
    end

    task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d..%0d at %0t", nm, act, lo, hi, $time);
        end
    endtask

    // Reference: a window of T_PS holds floor or ceil of T/P edges; sampling adds +-1.
    task automatic expect_range(input int s, output longint lo, output longint hi);
        longint p;
        if (s >= RINGS) begin
            lo = 0;
            hi = 0;
        end else begin
            p  = 2 * longint'(half_ps[s]);
            lo = T_PS / p - 1;
            hi = (T_PS + p - 1) / p + 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have    = 1'b0;
            hold_lo = 0;
            hold_hi = 0;
        end else begin
            edge_n++;
            if (have && edge_n == acc + DONE_OFS) begin
                hold_lo = lo_cnt;
                hold_hi = hi_cnt;
            end
            if (start && (!have || edge_n >= acc + DONE_OFS + 1)) begin
                acc  = edge_n;
                have = 1'b1;
                expect_range(int'(sel), lo_cnt, hi_cnt);
            end
        end
    end

    always @(negedge clk) begin
        bit eb;
        bit ev;
        if (chk_en) begin
            eb = rst_n && have && edge_n >= acc && edge_n <= acc + DONE_OFS - 1;
            ev = rst_n && have && edge_n == acc + DONE_OFS;
            chk("busy", busy == eb, busy, eb);
            chk("valid", valid == ev, valid, ev);
            chk_rng("count", count, hold_lo, hold_hi);
        end
    end

    task automatic pulse_start(input logic [SEL_W-1:0] s, output int drive_edge);
        @(posedge clk);
        #1;
        drive_edge = edge_n;
        sel   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output longint cnt, output int at_edge);
        bit got;
        got = 1'b0;
        cnt = 0;
        at_edge = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (valid) begin
                got = 1'b1;
                cnt = count;
                at_edge = edge_n;
            end
        end
        chk("valid_timeout", got, got, 1);
    endtask

    function automatic logic [15:0] b2g(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        int     d;
        int     at;
        longint c1;
        longint c2;
        int     nv;
        logic [15:0] pre;

        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy == 1'b0, busy, 0);
        chk("rst_valid", valid == 1'b0, valid, 0);
        chk("rst_count", count == '0, count, 0);
        rst_n = 1'b1;

        // Basic: 2 ns ring on slot 0
        half_ps[0] = 1000;
        pulse_start(3'd0, d);
        wait_valid(1200, c1, at);
        chk("basic_latency", at == d + 1006, at - d, 1006);
        chk_rng("basic_count", c1, 4999, 5001);

        // Reset in the middle of the gate window
        pulse_start(3'd0, d);
        repeat (300) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy == 1'b0, busy, 0);
        chk("midrst_count", count == '0, count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        nv = 0;
        repeat (1100) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk("midrst_no_valid", nv == 0, nv, 0);

        // Select: 40 ns ring on slot 5, then an unpopulated slot
        half_ps[5] = 20000;
        pulse_start(3'd5, d);
        wait_valid(1200, c1, at);
        chk_rng("sel5_count", c1, 249, 251);
        pulse_start(3'd7, d);
        wait_valid(1200, c1, at);
        chk("sel7_count", c1 == 0, c1, 0);

        // Wrap: preload the Gray counter just below the top
        pre = b2g(16'hFF00);
        @(posedge clk);
        #2 force dut.gray_q = pre;
        #4 release dut.gray_q;
        pulse_start(3'd0, d);
        wait_valid(1200, c1, at);
        chk_rng("wrap_count", c1, 4999, 5001);

        // Busy: extra starts with other selects during the run are ignored
        half_ps[2] = 3000;
        pulse_start(3'd2, d);
        repeat (200) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            sel   = (k[0]) ? 3'd7 : 3'd5;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (150) @(posedge clk);
        end
        #1 sel = 3'd0;
        nv = 0;
        c1 = 0;
        repeat (700) begin
            @(negedge clk);
            if (valid) begin
                nv++;
                c1 = count;
            end
        end
        chk("busy_one_valid", nv == 1, nv, 1);
        chk_rng("busy_count", c1, 1665, 1668);

        // Back-to-back: start in the cycle after o_valid
        pulse_start(3'd0, d);
        wait_valid(1200, c1, at);
        pulse_start(3'd0, d);
        chk("b2b_accepted", busy == 1'b1, busy, 1);
        wait_valid(1200, c2, at);
        chk_rng("b2b_match", c2, c1 - 1, c1 + 1);

        // Randomised runs with stray starts, including in the DONE cycle
        for (int n = 0; n < 12; n++) begin
            half_ps[$urandom_range(RINGS - 1, 0)] = int'($urandom_range(20000, 1000));
            repeat ($urandom_range(20, 0)) @(posedge clk);
            pulse_start(SEL_W'($urandom_range(7, 0)), d);
            nv = 0;
            for (int i = 0; i < 1200; i++) begin
                @(posedge clk);
                #1;
                if (valid) begin
                    nv = 1;
                    start = 1'b0;
                    break;
                end
                start = ($urandom_range(30, 0) == 0);
                if (start) sel = SEL_W'($urandom_range(7, 0));
            end
            start = 1'b0;
            chk("rand_valid_seen", nv == 1, nv, 1);
        end

        repeat (5) @(posedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
